// File: rtl/binary_adder_pkg.sv
// binary_adder_pkg
// Shared definitions for the registered binary adder.
//   DEFAULT_WIDTH : default operand/sum width in bits.
//   add_ref()     : arithmetic reference add, {carry, sum} = a + b + c_in.
//                   It is written at the maximum legal width (32 bits).
//                   Callers zero-extend narrower operands and keep the low
//                   WIDTH+1 bits. Those bits are exact because the true
//                   result is always below 2^(WIDTH+1).
package binary_adder_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int MAX_WIDTH     = 32;

  function automatic logic [MAX_WIDTH:0] add_ref(
    input logic [MAX_WIDTH-1:0] a,
    input logic [MAX_WIDTH-1:0] b,
    input logic                 c_in
  );
    return {1'b0, a} + {1'b0, b} + {{MAX_WIDTH{1'b0}}, c_in};
  endfunction

endpackage

// File: rtl/binary_adder_sync_if.sv
// binary_adder_sync_if
// Operand/result bundle for binary_adder_sync.
//   in_valid, a, b, c_in            : request side, driven by the master.
//   out_valid, sum, c_out, mismatch : result side, driven by the adder (slave).
// Handshake: there is no ready signal, so the adder accepts every beat.
// a, b and c_in are meaningful only when in_valid=1. out_valid is in_valid
// delayed by exactly one clock. sum, c_out and mismatch are meaningful while
// out_valid=1, and hold their last loaded value otherwise.
interface binary_adder_sync_if #(
  parameter int WIDTH = binary_adder_pkg::DEFAULT_WIDTH
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             mismatch;

  modport master (
    output in_valid, a, b, c_in,
    input  out_valid, sum, c_out, mismatch
  );

  modport slave (
    input  in_valid, a, b, c_in,
    output out_valid, sum, c_out, mismatch
  );
endinterface

// File: rtl/binary_adder_sync_full_adder.sv
// full_adder
// One-bit full adder. This is the cell of the ripple-carry chain.
//   a, b : operand bits
//   ci   : carry in
//   s    : sum bit,  a ^ b ^ ci
//   co   : carry out, (a & b) | (ci & (a ^ b))
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;

  // Propagate term, shared by the sum and carry equations.
  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);
endmodule

// File: rtl/binary_adder_sync.sv
// binary_adder_sync
// Registered WIDTH-bit adder with carry-in and carry-out. The latency is one
// cycle and a new operation is accepted every cycle.
// Ports:
//   clk : clock. All state updates on the rising edge.
//   rst : synchronous, active-high reset. It has priority over bus.in_valid.
//   bus : binary_adder_sync_if.slave
//         (in_valid, a, b, c_in in; out_valid, sum, c_out, mismatch out)
// sum and c_out always come from a ripple chain of full_adder cells.
// Build option BINARY_ADDER_CROSS_CHECK_EN adds a behavioural adder in
// parallel. mismatch then registers the disagreement between the two results
// on every valid cycle. Without the option, mismatch is tied to 0.
module binary_adder_sync
  import binary_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic               clk,
  input logic               rst,
  binary_adder_sync_if.slave bus
);

  logic [WIDTH-1:0] a_w;
  logic [WIDTH-1:0] b_w;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_w;
  logic             mismatch_w;

  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             c_out_q;
  logic             mismatch_q;

  assign a_w      = bus.a;
  assign b_w      = bus.b;
  assign carry[0] = bus.c_in;

  // carry[i+1] is the carry out of stage i. carry[WIDTH] is c_out.
  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    full_adder u_fa (
      .a  (a_w[i]),
      .b  (b_w[i]),
      .ci (carry[i]),
      .s  (sum_w[i]),
      .co (carry[i+1])
    );
  end

`ifdef BINARY_ADDER_CROSS_CHECK_EN
  logic [MAX_WIDTH:0] ref_full;

  // The operands are zero-extended to the reference width. The full result
  // is compared so that a ripple result with a stray carry also shows up.
  assign ref_full   = add_ref(MAX_WIDTH'(a_w), MAX_WIDTH'(b_w), bus.c_in);
  assign mismatch_w = (ref_full != (MAX_WIDTH + 1)'({carry[WIDTH], sum_w}));
`else
  assign mismatch_w = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      c_out_q     <= 1'b0;
      mismatch_q  <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      // The result registers hold across idle cycles.
      if (bus.in_valid) begin
        sum_q      <= sum_w;
        c_out_q    <= carry[WIDTH];
        mismatch_q <= mismatch_w;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.c_out     = c_out_q;
  assign bus.mismatch  = mismatch_q;

endmodule

// File: tb/tb_binary_adder_sync.sv
// tb_binary_adder_sync
// Self-checking bench for binary_adder_sync at WIDTH=4.
// A plain-arithmetic model tracks the expected outputs, and a compare
// process checks the DUT against it on every falling edge. Directed steps
// also pin their results to hand-computed literals.
module tb_binary_adder_sync;
  import binary_adder_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  binary_adder_sync_if #(.WIDTH(W)) bus ();

  binary_adder_sync #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // {c_out, sum} is the unsigned integer a + b + c_in split at bit W.
  // Reset clears everything. out_valid follows in_valid one cycle late.
  // The result fields update only on valid beats.
  bit         model_live = 1'b0;
  bit         m_valid;
  int         m_sum;
  int         m_cout;

  always @(posedge clk) begin
    int total;
    if (rst) begin
      m_valid    = 1'b0;
      m_sum      = 0;
      m_cout     = 0;
      model_live = 1'b1;
    end else if (model_live) begin
      m_valid = bus.in_valid;
      if (bus.in_valid) begin
        total  = int'(bus.a) + int'(bus.b) + int'(bus.c_in);
        m_sum  = total % (1 << W);
        m_cout = total / (1 << W);
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (model_live) begin
      check("cmp_out_valid", 32'(bus.out_valid), 32'(m_valid));
      check("cmp_sum",       32'(bus.sum),       32'(m_sum));
      check("cmp_c_out",     32'(bus.c_out),     32'(m_cout));
      check("cmp_mismatch",  32'(bus.mismatch),  32'd0);
    end
  end

  // ---------------- driver ----------------
  // Drives one beat, then waits until just after the edge that samples it.
  task automatic drive(input logic r, input logic v, input int av, input int bv, input logic cv);
    rst          = r;
    bus.in_valid = v;
    bus.a        = W'(av);
    bus.b        = W'(bv);
    bus.c_in     = cv;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic v, input int s, input logic c);
    check({name, "_valid"}, 32'(bus.out_valid), 32'(v));
    check({name, "_sum"},   32'(bus.sum),       32'(s));
    check({name, "_c_out"}, 32'(bus.c_out),     32'(c));
    check({name, "_mism"},  32'(bus.mismatch),  32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [MAX_WIDTH:0] r;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.c_in     = 1'b0;

    // Pin the shared reference function.
    r = add_ref(32'd15, 32'd15, 1'b1);
    check("add_ref_15_15_1", 32'(r), 32'd31);
    r = add_ref(32'hFFFF_FFFF, 32'd0, 1'b1);
    check("add_ref_wrap32", 32'(r[32]), 32'd1);

    // Reset holds outputs low even with a valid operation presented.
    drive(1, 1, 5, 6, 0);  expect_out("reset1", 0, 0, 0);
    drive(1, 1, 5, 6, 0);  expect_out("reset2", 0, 0, 0);

    drive(0, 1, 3, 4, 0);    expect_out("basic",     1, 7, 0);
    drive(0, 1, 7, 8, 1);    expect_out("carry",     1, 0, 1);
    drive(0, 1, 15, 15, 1);  expect_out("max",       1, 15, 1);
    drive(0, 1, 14, 14, 1);  expect_out("max_m1",    1, 13, 1);
    drive(0, 1, 0, 0, 0);    expect_out("zero",      1, 0, 0);
    drive(0, 1, 15, 0, 1);   expect_out("cin_carry", 1, 0, 1);

    // Back-to-back streaming, then an idle cycle that must hold the sum.
    drive(0, 1, 1, 1, 0);  expect_out("stream1", 1, 2, 0);
    drive(0, 1, 2, 2, 1);  expect_out("stream2", 1, 5, 0);
    drive(0, 1, 9, 9, 0);  expect_out("stream3", 1, 2, 1);
    drive(0, 0, 3, 3, 1);  expect_out("hold",    0, 2, 1);

    // A valid operation in a reset cycle is discarded.
    drive(1, 1, 9, 9, 1);  expect_out("reset_mid", 0, 0, 0);
    drive(0, 1, 6, 5, 0);  expect_out("after_rst", 1, 11, 0);

    // Randomized traffic, checked each cycle by the compare process.
    for (int i = 0; i < 10000; i++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
            int'($urandom_range(0, (1 << W) - 1)),
            int'($urandom_range(0, (1 << W) - 1)),
            1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
